// File: rtl/rv32_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// rv32_mem_port_arbiter
//
// Purpose:
//   Shares one memory port between two requesters: requester 0 is the
//   multicycle core and requester 1 is a DMA/debug master. A granted request
//   is latched and driven to memory for RD_LATENCY cycles. The captured read
//   data and exception mask are then returned to the owner with a one-cycle
//   rvalid pulse. Stores are acknowledged the same way. Only one transaction
//   is in flight at a time.
//
// Configuration macro:
//   RV32_ARB_ROUND_ROBIN_EN - when defined, a tie (both requesting) goes to
//                             the requester that did not own the previous
//                             transaction. The first tie after reset goes to
//                             requester 0. When undefined, requester 0
//                             always wins a tie.
//
// Parameters:
//   RD_LATENCY : cycles by which mem_rd_data lags mem_addr (1..15)
//   CNT_W      : latency counter width, RD_LATENCY < 2**CNT_W
//
// Ports:
//   clk, rst              clock (rising edge), async active-low reset
//   req[1:0]              per-requester request, held until its gnt
//   addr0/1, wdata0/1     request address / store data
//   we[1:0], access0/1    store flag / access size per requester
//   gnt[1:0]              one-hot pulse: request latched on the previous edge
//   rvalid[1:0]           one-hot pulse: rdata/rexc valid for that requester
//   rdata, rexc           captured memory read data / exception mask
//   mem_addr, mem_wr_data latched request driven to memory
//   mem_wr_ena            single-cycle store strobe
//   mem_access            latched access size
//   mem_rd_data           memory read data
//   mem_exception         memory exception mask
// ---------------------------------------------------------------------------
package rv32_mem_pkg;
    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2
    } mem_access_t;

    typedef logic [3:0] mem_exception_mask_t;
endpackage

module rv32_mem_port_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [31:0]         addr0,
    input  logic [31:0]         addr1,
    input  logic [31:0]         wdata0,
    input  logic [31:0]         wdata1,
    input  logic [1:0]          we,
    input  mem_access_t         access0,
    input  mem_access_t         access1,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [31:0]         rdata,
    output mem_exception_mask_t rexc,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wr_data,
    output logic                mem_wr_ena,
    output mem_access_t         mem_access,
    input  logic [31:0]         mem_rd_data,
    input  mem_exception_mask_t mem_exception
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LATENCY - 1);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    counter_reg, counter_next;
    logic                owner_reg, owner_next;
    logic [1:0]          gnt_reg, gnt_next;
    logic [1:0]          rvalid_reg, rvalid_next;
    logic [31:0]         rdata_reg, rdata_next;
    mem_exception_mask_t rexc_reg, rexc_next;
    logic [31:0]         mem_addr_reg, mem_addr_next;
    logic [31:0]         mem_wr_data_reg, mem_wr_data_next;
    logic                mem_wr_ena_reg, mem_wr_ena_next;
    mem_access_t         mem_access_reg, mem_access_next;
    logic                winner;

`ifdef RV32_ARB_ROUND_ROBIN_EN
    logic last_owner_reg, last_owner_next;

    // On a tie the previous owner yields; a lone requester always wins.
    always_comb begin
        if (req == 2'b11) begin
            winner = ~last_owner_reg;
        end else begin
            winner = req[1];
        end
    end
`else
    // Requester 0 wins whenever it is requesting.
    always_comb begin
        winner = ~req[0];
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            counter_reg     <= '0;
            owner_reg       <= 1'b0;
            gnt_reg         <= 2'b00;
            rvalid_reg      <= 2'b00;
            rdata_reg       <= '0;
            rexc_reg        <= '0;
            mem_addr_reg    <= '0;
            mem_wr_data_reg <= '0;
            mem_wr_ena_reg  <= 1'b0;
            mem_access_reg  <= MEM_ACCESS_WORD;
`ifdef RV32_ARB_ROUND_ROBIN_EN
            last_owner_reg  <= 1'b1;
`endif
        end else begin
            state_reg       <= state_next;
            counter_reg     <= counter_next;
            owner_reg       <= owner_next;
            gnt_reg         <= gnt_next;
            rvalid_reg      <= rvalid_next;
            rdata_reg       <= rdata_next;
            rexc_reg        <= rexc_next;
            mem_addr_reg    <= mem_addr_next;
            mem_wr_data_reg <= mem_wr_data_next;
            mem_wr_ena_reg  <= mem_wr_ena_next;
            mem_access_reg  <= mem_access_next;
`ifdef RV32_ARB_ROUND_ROBIN_EN
            last_owner_reg  <= last_owner_next;
`endif
        end
    end

    always_comb begin
        state_next       = state_reg;
        counter_next     = counter_reg;
        owner_next       = owner_reg;
        gnt_next         = 2'b00;
        rvalid_next      = 2'b00;
        rdata_next       = rdata_reg;
        rexc_next        = rexc_reg;
        mem_addr_next    = mem_addr_reg;
        mem_wr_data_next = mem_wr_data_reg;
        mem_access_next  = mem_access_reg;
        // Strobe is only ever set on the grant edge, so a store produces
        // exactly one write cycle (the first S_ACCESS cycle).
        mem_wr_ena_next  = 1'b0;
`ifdef RV32_ARB_ROUND_ROBIN_EN
        last_owner_next  = last_owner_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (req != 2'b00) begin
                    gnt_next         = winner ? 2'b10 : 2'b01;
                    mem_addr_next    = winner ? addr1 : addr0;
                    mem_wr_data_next = winner ? wdata1 : wdata0;
                    mem_access_next  = winner ? access1 : access0;
                    mem_wr_ena_next  = we[winner];
                    owner_next       = winner;
                    counter_next     = '0;
                    state_next       = S_ACCESS;
                end
            end
            S_ACCESS: begin
                counter_next = counter_reg + CNT_W'(1);
                if (counter_reg == LAST_CNT) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                // Data is valid this cycle; the rvalid pulse lines up with
                // the freshly captured rdata/rexc in the following S_IDLE cycle.
                rdata_next  = mem_rd_data;
                rexc_next   = mem_exception;
                rvalid_next = owner_reg ? 2'b10 : 2'b01;
`ifdef RV32_ARB_ROUND_ROBIN_EN
                last_owner_next = owner_reg;
`endif
                state_next  = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign gnt         = gnt_reg;
    assign rvalid      = rvalid_reg;
    assign rdata       = rdata_reg;
    assign rexc        = rexc_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wr_data = mem_wr_data_reg;
    assign mem_wr_ena  = mem_wr_ena_reg;
    assign mem_access  = mem_access_reg;

endmodule

// File: tb/tb_rv32_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv32_mem_port_arbiter
//
// Scoreboard bench for rv32_mem_port_arbiter. A reference model samples the
// requests on every rising edge, decides grants from the arbitration rules
// and pushes the expected transaction (grant cycle, owner, latched fields,
// returned data/exception). A separate monitor on the falling edge pops and
// compares gnt, mem_* fields, the store strobe, rvalid and rdata/rexc.
// The memory is a pure function of the address, delayed RD_LATENCY cycles.
// Honours RV32_ARB_ROUND_ROBIN_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_rv32_mem_port_arbiter;
    import rv32_mem_pkg::*;

    localparam int L = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req;
    logic [31:0]         t_addr [2];
    logic [31:0]         t_wdata [2];
    logic [1:0]          we;
    mem_access_t         t_acc [2];
    logic [1:0]          gnt;
    logic [1:0]          rvalid;
    logic [31:0]         rdata;
    mem_exception_mask_t rexc;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_wr_data;
    logic                mem_wr_ena;
    mem_access_t         mem_access;
    logic [31:0]         mem_rd_data;
    mem_exception_mask_t mem_exception;

    rv32_mem_port_arbiter #(.RD_LATENCY(L), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .addr0         (t_addr[0]),
        .addr1         (t_addr[1]),
        .wdata0        (t_wdata[0]),
        .wdata1        (t_wdata[1]),
        .we            (we),
        .access0       (t_acc[0]),
        .access1       (t_acc[1]),
        .gnt           (gnt),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .rexc          (rexc),
        .mem_addr      (mem_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_wr_ena    (mem_wr_ena),
        .mem_access    (mem_access),
        .mem_rd_data   (mem_rd_data),
        .mem_exception (mem_exception)
    );

    always #5 clk = ~clk;

    // ---------------- memory environment ----------------
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h1000_0010) return 32'hDEAD_BEEF;
        return {a[15:0], a[31:16]} ^ 32'h5EED_1234;
    endfunction

    function automatic mem_exception_mask_t exc_fn(input logic [31:0] a);
        if (a[31:28] == 4'hE) return a[7:4] | 4'h1;
        return 4'h0;
    endfunction

    logic [31:0] addr_pipe [L];
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) addr_pipe[i] <= addr_pipe[i-1];
        addr_pipe[0] <= mem_addr;
    end
    assign mem_rd_data   = rd_fn(addr_pipe[L-1]);
    assign mem_exception = exc_fn(addr_pipe[L-1]);

    // ---------------- scoreboard ----------------
    typedef struct {
        int                  gcyc;
        int                  who;
        logic [31:0]         addr;
        logic [31:0]         wdata;
        logic                st;
        mem_access_t         acc;
        logic [31:0]         rdata;
        mem_exception_mask_t exc;
    } txn_t;

    txn_t exp_q [$];
    int   ghist [$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference model: arbiter is free again L+2 edges after a grant edge.
    int   next_free = 0;
    int   last_owner = 1;
    txn_t mdl_t;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                exp_q.delete();
                next_free  = 0;
                last_owner = 1;
            end else if (cyc >= next_free && req != 2'b00) begin
                int w;
`ifdef RV32_ARB_ROUND_ROBIN_EN
                if (req == 2'b11) w = (last_owner == 0) ? 1 : 0;
                else              w = req[1] ? 1 : 0;
`else
                w = req[0] ? 0 : 1;
`endif
                mdl_t.gcyc  = cyc;
                mdl_t.who   = w;
                mdl_t.addr  = t_addr[w];
                mdl_t.wdata = t_wdata[w];
                mdl_t.st    = we[w];
                mdl_t.acc   = t_acc[w];
                mdl_t.rdata = rd_fn(t_addr[w]);
                mdl_t.exc   = exc_fn(t_addr[w]);
                exp_q.push_back(mdl_t);
                last_owner = w;
                next_free  = cyc + L + 2;
            end
        end
    end

    // Monitor
    txn_t mon_t;
    initial begin
        forever begin
            logic [1:0] eg;
            logic [1:0] erv;
            logic       ewe;
            @(negedge clk);
            if (!rst) begin
                chk("rst_gnt", 32'(gnt), 32'h0);
                chk("rst_rvalid", 32'(rvalid), 32'h0);
                chk("rst_wr_ena", 32'(mem_wr_ena), 32'h0);
            end else begin
                eg  = 2'b00;
                erv = 2'b00;
                ewe = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].gcyc <= cyc) begin
                    mon_t = exp_q[0];
                    if (cyc == mon_t.gcyc) begin
                        eg  = (mon_t.who == 1) ? 2'b10 : 2'b01;
                        ewe = mon_t.st;
                    end
                    if (cyc <= mon_t.gcyc + L) begin
                        chk("mem_addr", mem_addr, mon_t.addr);
                        chk("mem_wr_data", mem_wr_data, mon_t.wdata);
                        chk("mem_access", 32'(mem_access), 32'(mon_t.acc));
                    end
                    if (cyc == mon_t.gcyc + L + 1) begin
                        erv = (mon_t.who == 1) ? 2'b10 : 2'b01;
                        chk("rdata", rdata, mon_t.rdata);
                        chk("rexc", 32'(rexc), 32'(mon_t.exc));
                        $display("txn cyc=%0d owner=%0d %s addr=%h rdata=%h rexc=%h",
                                 cyc, mon_t.who, mon_t.st ? "store" : "load ",
                                 mon_t.addr, rdata, rexc);
                        void'(exp_q.pop_front());
                    end
                end
                chk("gnt", 32'(gnt), 32'(eg));
                chk("rvalid", 32'(rvalid), 32'(erv));
                chk("mem_wr_ena", 32'(mem_wr_ena), 32'(ewe));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic new_req(input int i, input logic [31:0] a, input logic [31:0] d,
                           input logic st, input mem_access_t ac);
        t_addr[i]  = a;
        t_wdata[i] = d;
        we[i]      = st;
        t_acc[i]   = ac;
        req[i]     = 1'b1;
    endtask

    task automatic rand_req(input int i);
        logic [31:0] a;
        a = $urandom();
        case ($urandom_range(0, 3))
            0:       a[31:28] = 4'h1;
            1:       a[31:28] = 4'h2;
            2:       a[31:28] = 4'hE;
            default: a[31:28] = 4'h3;
        endcase
        a[1:0] = 2'b00;
        new_req(i, a, $urandom(), 1'($urandom_range(0, 1)),
                mem_access_t'($urandom_range(0, 2)));
    endtask

    // One requester cycle: drop req on its gnt (optionally re-issue at once),
    // otherwise possibly raise a fresh request.
    task automatic step(input int p_new, input int b2b_pct);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (req[i] && gnt[i]) begin
                ghist.push_back(i);
                req[i] = 1'b0;
                if (int'($urandom_range(0, 99)) < b2b_pct) rand_req(i);
            end else if (!req[i] && int'($urandom_range(0, 99)) < p_new) begin
                rand_req(i);
            end
        end
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 200 && (req != 2'b00 || exp_q.size() != 0); c++) step(0, 0);
        step(0, 0);
        chk(nm, 32'(req != 2'b00 || exp_q.size() != 0), 32'h0);
    endtask

    initial begin
        int exp_tie [4];
`ifdef RV32_ARB_ROUND_ROBIN_EN
        exp_tie = '{0, 1, 0, 1};
`else
        exp_tie = '{0, 0, 0, 0};
`endif
        rst = 1'b0;
        req = 2'b00;
        we  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
            t_acc[i]   = MEM_ACCESS_WORD;
        end

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_rexc", 32'(rexc), 32'h0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_mem_wr_data", mem_wr_data, 32'h0);
        chk("reset_mem_access", 32'(mem_access), 32'(MEM_ACCESS_WORD));
        #2 rst = 1'b1;

        // Load by requester 0, then store by requester 1
        step(0, 0);
        new_req(0, 32'h1000_0010, 32'h0, 1'b0, MEM_ACCESS_WORD);
        drain("drain_load0");
        new_req(1, 32'h2000_0004, 32'h1234_5678, 1'b1, MEM_ACCESS_WORD);
        drain("drain_store1");

        // Held tie for four grants
        ghist.delete();
        rand_req(0);
        rand_req(1);
        for (int c = 0; c < 80 && ghist.size() < 4; c++) step(0, 100);
        chk("tie_count", 32'(ghist.size() >= 4), 32'h1);
        for (int k = 0; k < 4 && k < ghist.size(); k++) chk("tie_order", 32'(ghist[k]), 32'(exp_tie[k]));
        drain("drain_tie");

        // Async reset during the strobe cycle of a store
        new_req(1, 32'h2000_0008, 32'hCAFE_F00D, 1'b1, MEM_ACCESS_WORD);
        for (int c = 0; c < 30 && req[1]; c++) step(0, 0);
        chk("rst_store_granted", 32'(req[1]), 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("async_wr_ena", 32'(mem_wr_ena), 32'h0);
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_rvalid", 32'(rvalid), 32'h0);
        chk("async_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (10) step(0, 0);

        // Exception then clean load
        new_req(0, 32'hE000_0040, 32'h0, 1'b0, MEM_ACCESS_HALF);
        drain("drain_exc");
        new_req(0, 32'h3000_0100, 32'h0, 1'b0, MEM_ACCESS_BYTE);
        drain("drain_clean");

        // Random traffic
        for (int c = 0; c < 1500; c++) step(25, 30);
        drain("drain_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
